fsm_inspeccion_multietapa: RTL and testbench
============================================

// Module: fsm_inspeccion_multietapa
// PURPOSE
//  Parametrised Moore inspection controller for one product lane. Walks a product
//  through N_PASS qualified inspection stages; any failed stage or a stage timeout
//  rejects, N_PASS consecutive passes approve. It adds a result-hold/ack handshake
//  and saturating approve/reject statistics. Sits between the sensor front end
//  (P, RI, RI_v) and the lane actuator/sorter that consumes E.
// PARAMETERS
//  N_PASS      2   passing stages required to approve (>=1)
//  TIMEOUT     15  max cycles waiting for RI_v per stage; 0 disables the timeout
//  HOLD_RESULT 0   0: result state lasts 1 cycle; 1: result held until ack
//  CNT_W       8   width of statistics counters
// PORTS
//  clk      in   1       clock, rising edge
//  reset    in   1       asynchronous, active-high reset
//  P        in   1       product present
//  RI       in   1       inspection result (1 = pass), qualified by RI_v
//  RI_v     in   1       RI valid strobe, one stage result per high cycle
//  ack      in   1       consumer accepts result (used only when HOLD_RESULT=1)
//  E        out  2       00 idle, 01 advance, 10 rejected, 11 approved
//  stage    out  SW      passes completed for current product, SW=$clog2(N_PASS+1)
//  timeout  out  1       high while in REJ entered via timeout
//  n_aprob  out  CNT_W   approved products, saturating
//  n_rech   out  CNT_W   rejected products (incl. timeouts), saturating
// BEHAVIOUR
//  - Reset (async, any time incl. mid-product): state=IDLE, E=00, stage=0,
//    timeout=0, timer=0, n_aprob=0, n_rech=0. Deassertion takes effect next edge.
//  - Moore: E and timeout decode from registered state only; no input->output path.
//  - States / E: IDLE=00, INSP=01, REJ=10, APR=11.
//  - IDLE: P=1 -> INSP, stage=0, timer=0; else stay.
//  - INSP, evaluated in priority order each edge:
//    1) P=0 -> IDLE (abort; no counter change; overrides a same-cycle RI_v).
//    2) RI_v & !RI -> REJ, timeout=0.
//    3) RI_v & RI: stage==N_PASS-1 -> APR; else stage+1, timer=0, stay.
//    4) TIMEOUT!=0 & timer==TIMEOUT-1 -> REJ, timeout=1.
//    5) else timer+1, stay.
//  - Latency: RI_v sampled at edge k -> new E visible after edge k (1 cycle).
//  - Counters increment at the edge entering REJ/APR, once per product; hold at
//    all-ones (no wrap). stage is cleared when entering IDLE.
//  - REJ/APR, HOLD_RESULT=0: -> IDLE next edge unconditionally (ack ignored).
//  - REJ/APR, HOLD_RESULT=1: stay while ack=0; ack=1 -> IDLE. P, RI_v ignored
//    while holding; ack ignored in IDLE/INSP. Product arriving during hold is
//    seen from IDLE on the following edge if P still high.
//  - timer width $clog2(TIMEOUT+1) (min 1); unused when TIMEOUT=0.
//  - Illegal state encoding -> IDLE on next edge.
// STRUCTURE
//  - Package insp_pkg: state enum (IDLE, INSP, REJ, APR), E code localparams
//    E_NADA=2'b00, E_AVANZA=2'b01, E_RECHAZO=2'b10, E_APROB=2'b11.
//  - One sub-module: insp_sat_counter #(W) (clk, reset, inc, q), instanced
//    twice for n_aprob / n_rech. FSM, stage and timer live in the top.
// TESTING
//  - N_PASS=2: P=1, two RI_v pulses with RI=1 -> E 00,01,01,11,00; n_aprob=1.
//  - N_PASS=3: P=1, RI_v&RI=1 then RI_v&RI=0 -> E=10 after 2nd strobe, stage=1
//    during REJ, n_rech=1, timeout=0.
//  - TIMEOUT=4: P=1, no RI_v -> E=01 for 4 cycles then E=10, timeout=1, n_rech=1.
//  - P drops in INSP same cycle as RI_v&RI=0 -> IDLE, counters unchanged.
//  - HOLD_RESULT=1: approve, ack=0 for 5 cycles -> E=11 held; ack=1 -> E=00.
//  - CNT_W=2: 5 rejects -> n_rech=3 (saturated); reset mid-INSP -> all zero.

Source files
------------

// File: rtl/insp_pkg.sv
// Shared types for the multi-stage inspection controller:
// FSM state encoding and the E result codes seen by the sorter.
package insp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INSP = 2'b01,
        REJ  = 2'b10,
        APR  = 2'b11
    } state_t;

    localparam logic [1:0] E_NADA    = 2'b00;
    localparam logic [1:0] E_AVANZA  = 2'b01;
    localparam logic [1:0] E_RECHAZO = 2'b10;
    localparam logic [1:0] E_APROB   = 2'b11;

    function automatic logic [1:0] e_code(input state_t s);
        logic [1:0] e;
        e = E_NADA;
        case (s)
            INSP:    e = E_AVANZA;
            REJ:     e = E_RECHAZO;
            APR:     e = E_APROB;
            default: e = E_NADA;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/insp_sat_counter.sv
// Saturating up-counter used for the approve/reject statistics.
// Holds at all-ones instead of wrapping.
module insp_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/fsm_inspeccion_multietapa.sv
// Moore inspection controller for one product lane: N_PASS qualified
// stages, per-stage timeout, optional result hold/ack, saturating stats.
module fsm_inspeccion_multietapa
    import insp_pkg::*;
#(
    parameter int N_PASS      = 2,
    parameter int TIMEOUT     = 15,
    parameter bit HOLD_RESULT = 1'b0,
    parameter int CNT_W       = 8,
    localparam int SW         = $clog2(N_PASS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             P,
    input  logic             RI,
    input  logic             RI_v,
    input  logic             ack,
    output logic [1:0]       E,
    output logic [SW-1:0]    stage,
    output logic             timeout,
    output logic [CNT_W-1:0] n_aprob,
    output logic [CNT_W-1:0] n_rech
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] LAST_STG = SW'(N_PASS - 1);
    localparam logic [SW-1:0] FULL_STG = SW'(N_PASS);
    localparam logic [TW-1:0] LAST_TMR = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tmo_q, tmo_d;
    logic          inc_aprob, inc_rech;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            timer_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        timer_d = timer_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (P) begin
                    state_d = INSP;
                    stage_d = '0;
                    timer_d = '0;
                    tmo_d   = 1'b0;
                end
            end
            INSP: begin
                // Product removal wins over any strobe in the same cycle
                if (!P) begin
                    state_d = IDLE;
                    stage_d = '0;
                end else if (RI_v && !RI) begin
                    state_d = REJ;
                    tmo_d   = 1'b0;
                end else if (RI_v) begin
                    if (stage_q == LAST_STG) begin
                        state_d = APR;
                        stage_d = FULL_STG;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        timer_d = '0;
                    end
                end else if ((TIMEOUT != 0) && (timer_q == LAST_TMR)) begin
                    state_d = REJ;
                    tmo_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REJ, APR: begin
                if (!HOLD_RESULT || ack) begin
                    state_d = IDLE;
                    stage_d = '0;
                    tmo_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
                timer_d = '0;
                tmo_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        E       = e_code(state_q);
        timeout = (state_q == REJ) && tmo_q;
        stage   = stage_q;
    end

    assign inc_aprob = (state_q == INSP) && (state_d == APR);
    assign inc_rech  = (state_q == INSP) && (state_d == REJ);

    insp_sat_counter #(.W(CNT_W)) u_cnt_aprob (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_aprob),
        .q     (n_aprob)
    );

    insp_sat_counter #(.W(CNT_W)) u_cnt_rech (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_rech),
        .q     (n_rech)
    );

endmodule

// File: tb/tb_fsm_inspeccion_multietapa.sv
// Bench for fsm_inspeccion_multietapa: vector table, hand sequences
// and randomized traffic against a behavioural lane model.
module tb_fsm_inspeccion_multietapa;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Lane A: N_PASS=2, TIMEOUT=4, no hold, 8-bit stats
    logic       ra, pa, ria, rva, aka;
    logic [1:0] ea;
    logic [1:0] sa;
    logic       ta;
    logic [7:0] naa, nra;

    // Lane B: N_PASS=3, timeout disabled, hold until ack, 2-bit stats
    logic       rb, pb, rib, rvb, akb;
    logic [1:0] eb;
    logic [1:0] sb;
    logic       tb_o;
    logic [1:0] nab, nrb;

    fsm_inspeccion_multietapa #(
        .N_PASS(2), .TIMEOUT(4), .HOLD_RESULT(1'b0), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset(ra), .P(pa), .RI(ria), .RI_v(rva), .ack(aka),
        .E(ea), .stage(sa), .timeout(ta), .n_aprob(naa), .n_rech(nra)
    );

    fsm_inspeccion_multietapa #(
        .N_PASS(3), .TIMEOUT(0), .HOLD_RESULT(1'b1), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(rb), .P(pb), .RI(rib), .RI_v(rvb), .ack(akb),
        .E(eb), .stage(sb), .timeout(tb_o), .n_aprob(nab), .n_rech(nrb)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bc(input logic p, input logic ri, input logic rv, input logic ak);
        pb = p; rib = ri; rvb = rv; akb = ak;
        step();
    endtask

    typedef struct {
        logic       p, ri, rv, ak;
        logic [1:0] e;
        int         stg;
        logic       tmo;
        int         na, nr;
    } vec_t;

    vec_t va[13];

    // Behavioural lane model: product/pass/wait bookkeeping
    typedef struct {
        bit busy;
        int res;      // 0 none, 1 rejected, 2 approved
        int pass;
        int waited;
        bit tmo;
        int na, nr;
    } m_t;

    function automatic m_t mstep(input m_t s, input bit p, input bit ri,
                                 input bit rv, input bit ak, input int np,
                                 input int to, input bit hold, input int cmax);
        m_t m = s;
        if (m.res != 0) begin
            if (!hold || ak) begin
                m.res = 0; m.pass = 0; m.tmo = 0;
            end
        end else if (!m.busy) begin
            if (p) begin
                m.busy = 1; m.pass = 0; m.waited = 0; m.tmo = 0;
            end
        end else if (!p) begin
            m.busy = 0; m.pass = 0;
        end else if (rv && !ri) begin
            m.busy = 0; m.res = 1; m.tmo = 0;
            if (m.nr < cmax) m.nr++;
        end else if (rv) begin
            if (m.pass + 1 == np) begin
                m.busy = 0; m.res = 2; m.pass = np;
                if (m.na < cmax) m.na++;
            end else begin
                m.pass++; m.waited = 0;
            end
        end else if (to != 0 && m.waited + 1 == to) begin
            m.busy = 0; m.res = 1; m.tmo = 1;
            if (m.nr < cmax) m.nr++;
        end else begin
            m.waited++;
        end
        return m;
    endfunction

    function automatic int m_e(input m_t m);
        if (m.res == 2) return 3;
        if (m.res == 1) return 2;
        return m.busy ? 1 : 0;
    endfunction

    m_t ma, mb;

    initial begin
        //       p  ri rv ak  E     stg tmo  na nr
        va[0]  = '{1'b0,1'b0,1'b0,1'b0,2'b00,0,1'b0,0,0};
        va[1]  = '{1'b1,1'b0,1'b0,1'b0,2'b01,0,1'b0,0,0};
        va[2]  = '{1'b1,1'b1,1'b1,1'b0,2'b01,1,1'b0,0,0};
        va[3]  = '{1'b1,1'b1,1'b1,1'b0,2'b11,2,1'b0,1,0};
        va[4]  = '{1'b0,1'b0,1'b0,1'b1,2'b00,0,1'b0,1,0};
        va[5]  = '{1'b1,1'b0,1'b0,1'b0,2'b01,0,1'b0,1,0};
        va[6]  = '{1'b1,1'b0,1'b0,1'b0,2'b01,0,1'b0,1,0};
        va[7]  = '{1'b1,1'b0,1'b0,1'b0,2'b01,0,1'b0,1,0};
        va[8]  = '{1'b1,1'b0,1'b0,1'b0,2'b01,0,1'b0,1,0};
        va[9]  = '{1'b1,1'b0,1'b0,1'b0,2'b10,0,1'b1,1,1};
        va[10] = '{1'b1,1'b0,1'b0,1'b0,2'b00,0,1'b0,1,1};
        va[11] = '{1'b1,1'b0,1'b0,1'b0,2'b01,0,1'b0,1,1};
        va[12] = '{1'b0,1'b0,1'b1,1'b0,2'b00,0,1'b0,1,1};

        ra = 1'b1; rb = 1'b1;
        pa = 0; ria = 0; rva = 0; aka = 0;
        pb = 0; rib = 0; rvb = 0; akb = 0;
        repeat (2) step();
        chk("rst_E", 32'(ea), 0);
        chk("rst_stage", 32'(sa), 0);
        chk("rst_timeout", 32'(ta), 0);
        chk("rst_n_aprob", 32'(naa), 0);
        chk("rst_n_rech", 32'(nra), 0);
        ra = 1'b0; rb = 1'b0;

        for (int i = 0; i < 13; i++) begin
            pa = va[i].p; ria = va[i].ri; rva = va[i].rv; aka = va[i].ak;
            step();
            chk($sformatf("vecA%0d_E", i), 32'(ea), 32'(va[i].e));
            chk($sformatf("vecA%0d_stage", i), 32'(sa), 32'(va[i].stg));
            chk($sformatf("vecA%0d_timeout", i), 32'(ta), 32'(va[i].tmo));
            chk($sformatf("vecA%0d_n_aprob", i), 32'(naa), 32'(va[i].na));
            chk($sformatf("vecA%0d_n_rech", i), 32'(nra), 32'(va[i].nr));
        end
        pa = 0; rva = 0;

        // Lane B: pass then fail, result held until ack
        bc(1, 0, 0, 0);
        chk("b_rej_insp_E", 32'(eb), 1);
        bc(1, 1, 1, 0);
        chk("b_rej_stage1", 32'(sb), 1);
        bc(1, 0, 1, 0);
        chk("b_rej_E", 32'(eb), 2);
        chk("b_rej_stage", 32'(sb), 1);
        chk("b_rej_timeout", 32'(tb_o), 0);
        chk("b_rej_n_rech", 32'(nrb), 1);
        repeat (3) bc(1, 1, 1, 0);
        chk("b_rej_hold_E", 32'(eb), 2);
        bc(0, 0, 0, 1);
        chk("b_rej_ack_E", 32'(eb), 0);
        chk("b_rej_ack_stage", 32'(sb), 0);

        // Lane B: approve, hold for 5 cycles without ack
        bc(1, 0, 0, 0);
        repeat (3) bc(1, 1, 1, 0);
        chk("b_apr_E", 32'(eb), 3);
        chk("b_apr_stage", 32'(sb), 3);
        chk("b_apr_n_aprob", 32'(nab), 1);
        for (int k = 0; k < 5; k++) begin
            bc(1, k[0], 1, 0);
            chk($sformatf("b_hold%0d_E", k), 32'(eb), 3);
        end
        chk("b_hold_n_aprob", 32'(nab), 1);
        bc(1, 0, 0, 1);
        chk("b_ack_E", 32'(eb), 0);
        bc(1, 0, 0, 0);
        chk("b_rearm_E", 32'(eb), 1);

        // Timeout disabled: lane waits indefinitely
        repeat (20) bc(1, 0, 0, 0);
        chk("b_notmo_E", 32'(eb), 1);
        chk("b_notmo_n_rech", 32'(nrb), 1);
        bc(0, 0, 0, 0);
        chk("b_abort_E", 32'(eb), 0);

        // Four more rejects saturate the 2-bit counter
        for (int k = 0; k < 4; k++) begin
            bc(1, 0, 0, 0);
            bc(1, 0, 1, 0);
            bc(0, 0, 0, 1);
        end
        chk("b_sat_n_rech", 32'(nrb), 3);
        chk("b_sat_n_aprob", 32'(nab), 1);

        // Asynchronous reset in the middle of an inspection
        bc(1, 1, 1, 0);
        chk("b_mid_E", 32'(eb), 1);
        #2 rb = 1'b1;
        #1;
        chk("b_arst_E", 32'(eb), 0);
        chk("b_arst_stage", 32'(sb), 0);
        chk("b_arst_n_rech", 32'(nrb), 0);
        chk("b_arst_n_aprob", 32'(nab), 0);

        // Randomized traffic on both lanes against the model
        ra = 1'b1;
        pa = 0; ria = 0; rva = 0; aka = 0;
        pb = 0; rib = 0; rvb = 0; akb = 0;
        step();
        ra = 1'b0; rb = 1'b0;
        ma = '{default: 0};
        mb = '{default: 0};
        for (int c = 0; c < 800; c++) begin
            pa  = ($urandom_range(0, 9) != 0);
            rva = ($urandom_range(0, 2) == 0);
            ria = ($urandom_range(0, 3) != 0);
            aka = ($urandom_range(0, 3) == 0);
            pb  = ($urandom_range(0, 9) != 0);
            rvb = ($urandom_range(0, 2) == 0);
            rib = ($urandom_range(0, 4) != 0);
            akb = ($urandom_range(0, 3) == 0);
            ma = mstep(ma, pa, ria, rva, aka, 2, 4, 1'b0, 255);
            mb = mstep(mb, pb, rib, rvb, akb, 3, 0, 1'b1, 3);
            step();
            chk("rnd_a_E", 32'(ea), 32'(m_e(ma)));
            chk("rnd_a_stage", 32'(sa), 32'(ma.pass));
            chk("rnd_a_timeout", 32'(ta), 32'(ma.res == 1 && ma.tmo));
            chk("rnd_a_n_aprob", 32'(naa), 32'(ma.na));
            chk("rnd_a_n_rech", 32'(nra), 32'(ma.nr));
            chk("rnd_b_E", 32'(eb), 32'(m_e(mb)));
            chk("rnd_b_stage", 32'(sb), 32'(mb.pass));
            chk("rnd_b_timeout", 32'(tb_o), 32'(mb.res == 1 && mb.tmo));
            chk("rnd_b_n_aprob", 32'(nab), 32'(mb.na));
            chk("rnd_b_n_rech", 32'(nrb), 32'(mb.nr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
